fifo_rx_packer: RTL
===================

# fifo_rx_packer

Receive-side byte FIFO for the UART path. It sits between the UART receiver and the CPU-facing register interface. Single received bytes are pushed into a byte ring buffer. The consumer pops 1..EntryBytes bytes per request and gets them back packed into one word, oldest byte most significant. This is the inverse of the byte-unpacking done on the transmit side.

## Interface
Parameters:
- EntryBytes, 4: maximum bytes per read; read_data_o is 8*EntryBytes bits.
- DepthBytes, 64: ring capacity in bytes; must be a power of two, at least 2*EntryBytes.
- Watermark, 8: irq_o asserts while count reaches this value; range 1..DepthBytes.

Ports:
- clk_i, input, 1: single clock; all logic is rising-edge.
- reset_ni, input, 1: asynchronous, active-low reset.
- byte_valid_i, input, 1: one-cycle strobe from the UART receiver.
- byte_data_i, input, 8: received byte, sampled when byte_valid_i=1.
- read_enable_i, input, 1: pop request.
- read_width_i, input, $clog2(EntryBytes)+1: bytes to pop, legal range 1..EntryBytes.
- read_data_o, output, 8*EntryBytes: packed result, right-justified.
- read_valid_o, output, 1: one-cycle pulse; read_data_o is fresh.
- read_error_o, output, 1: one-cycle pulse; the request was rejected.
- count_o, output, $clog2(DepthBytes)+1: bytes currently stored.
- empty_o, output, 1: high when count_o == 0.
- irq_o, output, 1: high when count_o >= Watermark.
- overflow_o, output, 1: sticky; a received byte was dropped.
- clear_overflow_i, input, 1: synchronous clear of overflow_o.

## Operation
- Storage: byte array mem[DepthBytes] plus the registers wr_ptr, rd_ptr and count.
  - Pointers are $clog2(DepthBytes) bits and wrap modulo DepthBytes with no special case.
- Push: taken when byte_valid_i=1 and the pre-edge count < DepthBytes.
  - mem[wr_ptr] <= byte_data_i; wr_ptr += 1.
- Push when full (pre-edge count == DepthBytes): the byte is dropped and overflow_o <= 1.
  - This holds even if a pop happens in the same cycle.
- Pop accepted when read_enable_i=1 and 1 <= w <= EntryBytes and w <= pre-edge count, where w = read_width_i.
  - read_data_o <= sum over i=0..w-1 of mem[rd_ptr+i] << 8*(w-1-i).
  - Upper bits above 8*w are zero.
  - rd_ptr += w; read_valid_o <= 1.
- Pop rejected in all other cases (w=0, w>EntryBytes, w>count):
  - read_error_o <= 1.
  - rd_ptr, count and read_data_o are unchanged.
- Simultaneous push and accepted pop: count <= count + 1 - w.
  - A popped window never includes the byte being pushed on that edge.
- overflow_o: set on a dropped byte; cleared by clear_overflow_i.
  - If a drop and clear_overflow_i coincide, the set wins.
- read_data_o holds its value until the next accepted pop.

## Timing
- Every output is registered; there are no combinational paths from input to output.
- Pop latency: request sampled at edge N; read_data_o, read_valid_o, count_o, empty_o and irq_o all update at edge N.
  - The consumer sees them in the cycle after the request.
- Push latency: byte visible in count_o after 1 edge; it can be popped by a request in the following cycle.
- Back-to-back pops on consecutive cycles are allowed.
  - Each request is checked against the count already updated by the previous edge.
- Reset (asynchronous assert, any time, including mid-operation):
  - wr_ptr, rd_ptr, count_o, read_data_o, read_valid_o, read_error_o, overflow_o, irq_o cleared to 0.
  - empty_o set to 1.
  - mem contents are don't-care.
  - Reset release is assumed synchronized externally; the first push is legal on the first edge after release.

## Structure
- Shared constants in config_pkg: RxEntryBytes, RxDepthBytes, RxWatermark.
- Shared typedefs in config_pkg: RxPtrT as logic [$clog2(RxDepthBytes)-1:0], and RxCountT one bit wider.
- One sub-module, rx_byte_mem:
  - One synchronous write port.
  - EntryBytes combinational read ports at rd_ptr+i.
  - Keeps the packing mux and the pointer/count control in fifo_rx_packer.

## Test plan
- Push 0x11,0x22,0x33, then read w=3 → read_data_o=0x00112233, read_valid_o=1, count_o=0, empty_o=1.
- Push 0xAA, read w=2 → read_error_o=1, count_o stays 1; then read w=1 → read_data_o=0x000000AA.
- Fill 64 bytes 0x00..0x3F, push 0xFF → overflow_o=1, count_o=64; pop 16×w=4 → last read 0x3C3D3E3F (0xFF absent); clear_overflow_i → overflow_o=0.
- Wrap: push/pop 62 bytes, then push 0xA0..0xA3 across index 63→0, read w=4 → 0xA0A1A2A3.
- Same cycle push 0x55 and pop w=2 with count=2 → count_o=1; next read w=1 → 0x55; irq_o toggles exactly when crossing count 8.
- Assert reset_ni=0 mid-stream with count=5 → all outputs cleared immediately, without waiting for a clock; after release, push 0x7E and read w=1 → 0x7E.

Source files
------------

// File: rtl/config_pkg.sv
// Shared sizing constants and pointer/count types for the UART receive byte FIFO.
package config_pkg;

  localparam int unsigned RxEntryBytes = 4;
  localparam int unsigned RxDepthBytes = 64;
  localparam int unsigned RxWatermark  = 8;

  typedef logic [$clog2(RxDepthBytes)-1:0] RxPtrT;
  typedef logic [$clog2(RxDepthBytes):0]   RxCountT;

endpackage

// File: rtl/rx_byte_mem.sv
// Byte ring storage: one synchronous write port, EntryBytes combinational read
// ports at consecutive (wrapping) addresses starting at rd_ptr_i.
module rx_byte_mem
  import config_pkg::*;
#(
  parameter  int unsigned EntryBytes = RxEntryBytes,
  parameter  int unsigned DepthBytes = RxDepthBytes,
  localparam int unsigned PtrW       = $clog2(DepthBytes)
) (
  input  logic                           clk_i,
  input  logic                           wr_en_i,
  input  logic [PtrW-1:0]                wr_ptr_i,
  input  logic [7:0]                     wr_data_i,
  input  logic [PtrW-1:0]                rd_ptr_i,
  output logic [EntryBytes-1:0][7:0]     rd_bytes_c
);

  logic [7:0] r_mem [DepthBytes];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_ptr_i] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < int'(EntryBytes); g++) begin : g_rd
    assign rd_bytes_c[g] = r_mem[rd_ptr_i + PtrW'(g)];
  end

endmodule

// File: rtl/fifo_rx_packer.sv
// UART receive FIFO: single bytes pushed in, 1..EntryBytes bytes popped per
// request and packed oldest-byte-most-significant into a right-justified word.
module fifo_rx_packer
  import config_pkg::*;
#(
  parameter  int unsigned EntryBytes = RxEntryBytes,
  parameter  int unsigned DepthBytes = RxDepthBytes,
  parameter  int unsigned Watermark  = RxWatermark,
  localparam int unsigned PtrW       = $clog2(DepthBytes),
  localparam int unsigned CntW       = PtrW + 1,
  localparam int unsigned WidW       = $clog2(EntryBytes) + 1,
  localparam int unsigned DataW      = 8 * EntryBytes
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  input  logic             read_enable_i,
  input  logic [WidW-1:0]  read_width_i,
  output logic [DataW-1:0] read_data_o,
  output logic             read_valid_o,
  output logic             read_error_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             irq_o,
  output logic             overflow_o,
  input  logic             clear_overflow_i
);

  logic [PtrW-1:0]            r_wr_ptr;
  logic [PtrW-1:0]            r_rd_ptr;
  logic [CntW-1:0]            r_count;
  logic [DataW-1:0]           r_data;
  logic                       r_valid;
  logic                       r_error;
  logic                       r_empty;
  logic                       r_irq;
  logic                       r_overflow;

  logic                       w_push;
  logic                       w_drop;
  logic                       w_width_ok;
  logic                       w_pop;
  logic                       w_reject;
  logic [CntW-1:0]            w_pop_cnt;
  logic [CntW-1:0]            w_count_nxt;
  logic [EntryBytes-1:0][7:0] w_rd_bytes;
  logic [DataW-1:0]           w_pack;

  rx_byte_mem #(
    .EntryBytes (EntryBytes),
    .DepthBytes (DepthBytes)
  ) u_mem (
    .clk_i      (clk_i),
    .wr_en_i    (w_push),
    .wr_ptr_i   (r_wr_ptr),
    .wr_data_i  (byte_data_i),
    .rd_ptr_i   (r_rd_ptr),
    .rd_bytes_c (w_rd_bytes)
  );

  // Accept/reject decisions all use the pre-edge count, so a full FIFO drops a
  // byte even when a pop frees space on the same edge.
  always_comb begin
    w_push      = byte_valid_i && (r_count < CntW'(DepthBytes));
    w_drop      = byte_valid_i && !w_push;
    w_width_ok  = (read_width_i != '0) &&
                  (read_width_i <= WidW'(EntryBytes)) &&
                  (CntW'(read_width_i) <= r_count);
    w_pop       = read_enable_i && w_width_ok;
    w_reject    = read_enable_i && !w_width_ok;
    w_pop_cnt   = w_pop ? CntW'(read_width_i) : '0;
    w_count_nxt = r_count + CntW'(w_push) - w_pop_cnt;
  end

  // Shift in the first w bytes so the oldest lands most significant.
  always_comb begin
    w_pack = '0;
    for (int i = 0; i < int'(EntryBytes); i++) begin
      if (i < int'(read_width_i)) begin
        w_pack = (w_pack << 8) | DataW'(w_rd_bytes[i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_empty    <= 1'b1;
      r_irq      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(read_width_i);
        r_data   <= w_pack;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_irq   <= (w_count_nxt >= CntW'(Watermark));
      r_valid <= w_pop;
      r_error <= w_reject;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign read_data_o  = r_data;
  assign read_valid_o = r_valid;
  assign read_error_o = r_error;
  assign count_o      = r_count;
  assign empty_o      = r_empty;
  assign irq_o        = r_irq;
  assign overflow_o   = r_overflow;

endmodule
